// File: rtl/missed_dose_reader.sv
// Scans a window of pill-log RAM words, streams every missed-dose record out over valid/ready, and tallies misses per pill.
// Optional build macro MISS_COUNT_SAT_EN makes each 4-bit pill count saturate at 15 instead of wrapping.
module missed_dose_reader #(
  parameter logic [7:0] BASE_ADDR = 8'd0,
  parameter int         DEPTH     = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  output logic [7:0]  ramAddress,
  input  logic [27:0] ramData,
  output logic        missValid,
  input  logic        missReady,
  output logic [27:0] missRecord,
  output logic [11:0] missCounts,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, PUSH, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(DEPTH - 1);

  state_t      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  addr_q, addr_d;
  logic        vld_q, vld_d;
  logic [27:0] rec_q, rec_d;
  logic [11:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        advance;
  logic        is_miss;

  function automatic logic [3:0] bump(input logic [3:0] c);
`ifdef MISS_COUNT_SAT_EN
    return (c == 4'hF) ? c : c + 4'd1;
`else
    return c + 4'd1;
`endif
  endfunction

  assign is_miss = ramData[25] && !ramData[24] && (ramData[27:26] != 2'd0);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    addr_d  = addr_q;
    vld_d   = vld_q;
    rec_d   = rec_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    advance = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          index_d = 8'd0;
          cnt_d   = 12'd0;
          addr_d  = BASE_ADDR;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT:  state_d = CHECK;
      CHECK: begin
        if (is_miss) begin
          case (ramData[27:26])
            2'd1:    cnt_d[11:8] = bump(cnt_q[11:8]);
            2'd2:    cnt_d[7:4]  = bump(cnt_q[7:4]);
            2'd3:    cnt_d[3:0]  = bump(cnt_q[3:0]);
            default: cnt_d       = cnt_q;
          endcase
          rec_d   = ramData;
          vld_d   = 1'b1;
          state_d = PUSH;
        end else begin
          advance = 1'b1;
        end
      end
      PUSH: begin
        if (missReady) begin
          vld_d   = 1'b0;
          advance = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Address is loaded on the edge into ISSUE so RAM data lands exactly when CHECK samples it.
    if (advance) begin
      if (index_q == LAST_IDX) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        index_d = index_q + 8'd1;
        addr_d  = BASE_ADDR + index_q + 8'd1;
        state_d = ISSUE;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      index_q <= 8'd0;
      addr_q  <= 8'd0;
      vld_q   <= 1'b0;
      rec_q   <= 28'd0;
      cnt_q   <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      rec_q   <= rec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ramAddress = addr_q;
  assign missValid  = vld_q;
  assign missRecord = rec_q;
  assign missCounts = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_missed_dose_reader.sv
// Randomized bench for missed_dose_reader against a queue-based reference of the scan result.
module tb_missed_dose_reader;

  localparam logic [7:0] BASE  = 8'hF8;
  localparam int         DEPTH = 20;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [7:0]  ramAddress;
  logic [27:0] ramData;
  logic        missValid;
  logic        missReady;
  logic [27:0] missRecord;
  logic [11:0] missCounts;
  logic        busy;
  logic        done;

  logic [27:0] mem [256];
  logic [27:0] ram_d1;

  int n_checks = 0;
  int n_errors = 0;

  missed_dose_reader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetN(resetN), .start(start), .ramAddress(ramAddress),
    .ramData(ramData), .missValid(missValid), .missReady(missReady),
    .missRecord(missRecord), .missCounts(missCounts), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Two-cycle read latency RAM
  always @(posedge clk) begin
    ram_d1  <= mem[ramAddress];
    ramData <= ram_d1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] final_count(input int n);
`ifdef MISS_COUNT_SAT_EN
    return (n > 15) ? 4'd15 : 4'(n);
`else
    return 4'(n % 16);
`endif
  endfunction

  // ready_mode: 0 = always ready, 1 = random ready, 2 = ready held low for the first 5 offered cycles
  task automatic run_scan(input int ready_mode, input bit mid_start);
    logic [27:0] exp_q[$];
    logic [7:0]  exp_addr[$];
    logic [7:0]  got_addr[$];
    int          per_pill [4];
    logic [11:0] exp_cnt;
    logic [7:0]  last_addr;
    logic [27:0] prev_rec;
    logic [27:0] w;
    bit          prev_stall, seen_done;
    int          cyc, stalls, nxfer, low_left;

    per_pill = '{0, 0, 0, 0};
    for (int i = 0; i < DEPTH; i++) begin
      exp_addr.push_back(8'((int'(BASE) + i) % 256));
      w = mem[(int'(BASE) + i) % 256];
      if (w[25] && !w[24] && w[27:26] != 2'd0) begin
        exp_q.push_back(w);
        per_pill[w[27:26]]++;
      end
    end
    exp_cnt = {final_count(per_pill[1]), final_count(per_pill[2]), final_count(per_pill[3])};

    last_addr  = ramAddress;
    prev_stall = 1'b0;
    prev_rec   = 28'd0;
    seen_done  = 1'b0;
    stalls     = 0;
    nxfer      = 0;
    low_left   = 5;
    cyc        = 0;

    start = 1'b1;
    @(posedge clk); #1;
    for (cyc = 0; cyc < 2000; cyc++) begin
      case (ready_mode)
        0:       missReady = 1'b1;
        1:       missReady = 1'($urandom_range(0, 1));
        default: missReady = !(missValid && low_left > 0);
      endcase
      start = mid_start && (cyc == 4);
      @(negedge clk);
      if (ramAddress != last_addr) begin
        got_addr.push_back(ramAddress);
        last_addr = ramAddress;
      end
      if (prev_stall) begin
        check_val("hold_valid", 32'(missValid), 32'd1);
        check_val("hold_record", 32'(missRecord), 32'(prev_rec));
        check_val("no_done_in_stall", 32'(done), 32'd0);
      end
      if (missValid && missReady) begin
        if (exp_q.size() > 0) check_val("record", 32'(missRecord), 32'(exp_q.pop_front()));
        else check_val("extra_transfer", 32'(missRecord), 32'hFFFF_FFFF);
        nxfer++;
      end
      prev_stall = missValid && !missReady;
      if (prev_stall) begin
        stalls++;
        low_left--;
      end
      prev_rec = missRecord;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;

    check_val("done_seen", 32'(seen_done), 32'd1);
    check_val("scan_cycles", 32'(cyc + 2), 32'(3 * DEPTH + nxfer + stalls + 2));
    check_val("leftover_records", 32'(exp_q.size()), 32'd0);
    check_val("counts", 32'(missCounts), 32'(exp_cnt));
    check_val("busy_at_done", 32'(busy), 32'd1);
    check_val("addr_count", 32'(got_addr.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < got_addr.size(); i++)
      check_val($sformatf("addr[%0d]", i), 32'(got_addr[i]), 32'(exp_addr[i]));
    if (ready_mode == 2 && nxfer > 0) check_val("stall_cycles", 32'(stalls), 32'd5);

    missReady = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("done_one_cycle", 32'(done), 32'd0);
    check_val("idle_after_done", 32'(busy), 32'd0);
    check_val("counts_hold", 32'(missCounts), 32'(exp_cnt));
    @(posedge clk); #1;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++)
      mem[a] = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom)};
  endtask

  task automatic reset_during_push();
    bit found, seen;
    for (int a = 0; a < 256; a++) mem[a] = {2'd3, 1'b1, 1'b0, 24'($urandom)};
    missReady = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (missValid) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check_val("rst_reached_push", 32'(found), 32'd1);
    #2 resetN = 1'b0;
    #1;
    check_val("rst_valid", 32'(missValid), 32'd0);
    check_val("rst_record", 32'(missRecord), 32'd0);
    check_val("rst_counts", 32'(missCounts), 32'd0);
    check_val("rst_addr", 32'(ramAddress), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    resetN = 1'b1;
    missReady = 1'b1;
    seen = 1'b0;
    repeat (3 * DEPTH + 10) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check_val("rst_abandoned", 32'(seen), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    resetN    = 1'b0;
    start     = 1'b0;
    missReady = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 28'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_addr", 32'(ramAddress), 32'd0);
    check_val("reset_valid", 32'(missValid), 32'd0);
    check_val("reset_record", 32'(missRecord), 32'd0);
    check_val("reset_counts", 32'(missCounts), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    resetN = 1'b1;
    @(posedge clk); #1;

    run_scan(0, 1'b0);

    mem[8'(int'(BASE) + 2)] = 28'h6123000;
    run_scan(0, 1'b0);
    run_scan(2, 1'b0);

    for (int a = 0; a < 256; a++) mem[a] = 28'hA000000;
    run_scan(0, 1'b0);
    run_scan(1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      fill_random();
      run_scan(k % 2, k == 1);
    end

    reset_during_push();
    fill_random();
    run_scan(0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
